// File: rtl/fifo4bytes_ctrl_pkg.sv
// Shared types and parameter limits for the fifo4bytes controller.
package fifo4bytes_ctrl_pkg;

    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_PULSE = 2'd1,
        W_GAP   = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_CAPT = 2'd1,
        R_HOLD = 2'd2
    } rd_state_t;

    function automatic bit nreq_ok(input int n);
        return (n >= NREQ_MIN) && (n <= NREQ_MAX);
    endfunction

endpackage

// File: rtl/fifo4bytes.sv
// Four-entry byte FIFO with show-ahead read data: rdata is the head entry whenever !empty.
// Latency: a write is visible on empty/rdata the cycle after the write pulse.
// Backpressure: writes when full and reads when empty are ignored.
module fifo4bytes #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write,
    input  logic [DW-1:0] wdata,
    input  logic          read,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] r_mem [4];
    logic [1:0]    r_wp;
    logic [1:0]    r_rp;
    logic [2:0]    r_cnt;
    logic          w_do_wr;
    logic          w_do_rd;

    assign w_do_wr = write && !full;
    assign w_do_rd = read && !empty;
    assign empty   = (r_cnt == 3'd0);
    assign full    = (r_cnt == 3'd4);
    assign rdata   = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wp] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_wr) begin
                r_wp <= r_wp + 2'd1;
            end
            if (w_do_rd) begin
                r_rp <= r_rp + 2'd1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/fifo4bytes_ctrl_rr_pick.sv
// Round-robin priority select: first set request at or after the pointer, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; o_any low when no request is set.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic                    o_any,
    output logic [$clog2(NREQ)-1:0] o_idx
);

    localparam int PW = $clog2(NREQ);

    int w_j;

    // Scan from farthest to nearest so the closest request to the pointer wins.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_j   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (i_req[w_j]) begin
                o_any = 1'b1;
                o_idx = PW'(w_j);
            end
        end
    end

endmodule

// File: rtl/fifo4bytes_ctrl.sv
// Arbitrates NREQ byte producers onto one fifo4bytes write port and sequences its read port.
// Latency: grant/write pulse one cycle after request seen; rd_valid two cycles after !fifo_empty.
// Backpressure: no grant while fifo_full; rd_valid held until rd_ready, no new read meanwhile.
module fifo4bytes_ctrl
    import fifo4bytes_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         gnt,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [DW-1:0]           rd_data,
    output logic                    fifo_write,
    output logic [DW-1:0]           fifo_wdata,
    output logic                    fifo_read,
    input  logic [DW-1:0]           fifo_rdata,
    input  logic                    fifo_empty,
    input  logic                    fifo_full,
    output logic [$clog2(NREQ)-1:0] last_gnt
);

    localparam int PW = $clog2(NREQ);

    if (!nreq_ok(NREQ)) begin : g_bad_nreq
        $error("fifo4bytes_ctrl: NREQ out of range");
    end

    wr_state_t       r_wr_state;
    rd_state_t       r_rd_state;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [PW-1:0]   r_last_gnt;
    logic            r_fifo_write;
    logic [DW-1:0]   r_fifo_wdata;
    logic            r_fifo_read;
    logic            r_rd_valid;
    logic [DW-1:0]   r_rd_data;
    logic            w_any;
    logic [PW-1:0]   w_idx;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    assign gnt        = r_gnt;
    assign last_gnt   = r_last_gnt;
    assign fifo_write = r_fifo_write;
    assign fifo_wdata = r_fifo_wdata;
    assign fifo_read  = r_fifo_read;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;

    // W_GAP gives the fifo one cycle to update full before the next decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state   <= W_IDLE;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_last_gnt   <= '0;
            r_fifo_write <= 1'b0;
            r_fifo_wdata <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_any && !fifo_full) begin
                        r_fifo_write <= 1'b1;
                        r_fifo_wdata <= req_data[int'(w_idx)*DW +: DW];
                        r_gnt        <= NREQ'(1) << w_idx;
                        r_last_gnt   <= w_idx;
                        r_ptr        <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
                        r_wr_state   <= W_PULSE;
                    end
                end
                W_PULSE: begin
                    r_fifo_write <= 1'b0;
                    r_gnt        <= '0;
                    r_wr_state   <= W_GAP;
                end
                W_GAP: begin
                    r_wr_state <= W_IDLE;
                end
                default: begin
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // fifo_rdata is show-ahead, so the head byte is captured on the same edge that pops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state  <= R_IDLE;
            r_fifo_read <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (!fifo_empty && !r_rd_valid) begin
                        r_fifo_read <= 1'b1;
                        r_rd_state  <= R_CAPT;
                    end
                end
                R_CAPT: begin
                    r_fifo_read <= 1'b0;
                    r_rd_data   <= fifo_rdata;
                    r_rd_valid  <= 1'b1;
                    r_rd_state  <= R_HOLD;
                end
                R_HOLD: begin
                    if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo4bytes_ctrl.sv
// Scoreboard bench for fifo4bytes_ctrl driving a real fifo4bytes instance.
module tb_fifo4bytes_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        rd_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        fifo_write;
    logic [7:0]  fifo_wdata;
    logic        fifo_read;
    logic [7:0]  fifo_rdata;
    logic        fifo_empty;
    logic        fifo_full;
    logic [1:0]  last_gnt;

    int          errors = 0;
    int          checks = 0;
    int          exp_gnt[$];
    logic [7:0]  exp_rd[$];
    int          cyc = 0;
    int          last_wr = -1;
    bit          chk_spacing = 1'b0;
    bit          mon_en = 1'b0;

    fifo4bytes_ctrl #(.NREQ(4), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .fifo_write (fifo_write),
        .fifo_wdata (fifo_wdata),
        .fifo_read  (fifo_read),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .last_gnt   (last_gnt)
    );

    fifo4bytes #(.DW(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .write (fifo_write),
        .wdata (fifo_wdata),
        .read  (fifo_read),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT grants or hands over a byte.
    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt !== 4'h0) begin
                if (exp_gnt.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 32'h0);
                end else begin
                    chk("gnt_onehot", 32'(gnt), 32'(1) << exp_gnt[0]);
                    chk("last_gnt", 32'(last_gnt), 32'(exp_gnt[0]));
                    void'(exp_gnt.pop_front());
                end
            end
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    chk("rd_data", 32'(rd_data), 32'(exp_rd[0]));
                    void'(exp_rd.pop_front());
                end
            end
            if (fifo_write === 1'b1) begin
                chk("wr_when_full", 32'(fifo_full), 32'h0);
                if (chk_spacing && last_wr >= 0) begin
                    chk("wr_spacing", 32'(cyc - last_wr), 32'd3);
                end
                last_wr <= cyc;
            end
            if (fifo_read === 1'b1) begin
                chk("rd_when_empty", 32'(fifo_empty), 32'h0);
            end
        end
    end

    // Producer model: clears granted requests (unless keep) and optionally advances the byte.
    task automatic run_grants(input int n, input int max_cyc, input bit keep, input bit incr,
                              input bit drop, output int got);
        got = 0;
        for (int c = 0; c < max_cyc && got < n; c++) begin
            @(negedge clk);
            if (gnt != 4'h0) begin
                got++;
                for (int i = 0; i < 4; i++) begin
                    if (gnt[i]) begin
                        if (!keep) req[i] = 1'b0;
                        if (incr) req_data[i*8 +: 8] = req_data[i*8 +: 8] + 8'd1;
                    end
                end
                if (got == n && drop) req = 4'h0;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int c;
        c = 0;
        while ((exp_rd.size() != 0 || exp_gnt.size() != 0 || rd_valid || !fifo_empty) && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(c < max_cyc), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int n_rd;
        int n_vld;

        // Reset held two cycles with all producers requesting
        rst      = 1'b1;
        req      = 4'hF;
        req_data = 32'h1312_1110;
        rd_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_fifo_write", 32'(fifo_write), 32'h0);
            chk("rst_fifo_read", 32'(fifo_read), 32'h0);
            chk("rst_rd_valid", 32'(rd_valid), 32'h0);
            chk("rst_last_gnt", 32'(last_gnt), 32'h0);
            chk("rst_wdata", 32'(fifo_wdata), 32'h0);
        end

        // Round-robin with constant requests
        exp_gnt     = '{0, 1, 2, 3, 0};
        exp_rd      = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        chk_spacing = 1'b1;
        mon_en      = 1'b1;
        rst         = 1'b0;
        run_grants(5, 60, 1'b1, 1'b0, 1'b1, got);
        chk("rr_grants", 32'(got), 32'd5);
        wait_drain("rr_drain", 100);
        chk_spacing = 1'b0;

        // Fill the fifo with the consumer stalled (pointer now at 1)
        @(posedge clk); #1;
        rd_ready      = 1'b0;
        req_data[7:0] = 8'h01;
        req           = 4'h1;
        exp_gnt       = '{0, 0, 0, 0, 0, 0};
        exp_rd        = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_grants(5, 80, 1'b1, 1'b1, 1'b0, got);
        chk("full_grants", 32'(got), 32'd5);
        run_grants(1, 20, 1'b1, 1'b1, 1'b0, got);
        chk("full_no_grant", 32'(got), 32'd0);
        chk("full_flag", 32'(fifo_full), 32'd1);
        chk("full_hold_valid", 32'(rd_valid), 32'd1);
        chk("full_hold_data", 32'(rd_data), 32'h01);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        run_grants(1, 60, 1'b1, 1'b1, 1'b1, got);
        chk("full_resume", 32'(got), 32'd1);
        wait_drain("full_drain", 200);

        // Empty fifo: no reads may be issued
        n_rd  = 0;
        n_vld = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (fifo_read) n_rd++;
            if (rd_valid) n_vld++;
        end
        chk("empty_reads", 32'(n_rd), 32'd0);
        chk("empty_valid", 32'(n_vld), 32'd0);

        // Backpressure on a single byte (pointer at 1, producer 2 wins)
        @(posedge clk); #1;
        rd_ready        = 1'b0;
        req_data[23:16] = 8'hA5;
        req             = 4'h4;
        exp_gnt         = '{2};
        exp_rd          = '{8'hA5};
        run_grants(1, 20, 1'b0, 1'b0, 1'b1, got);
        chk("bp_grant", 32'(got), 32'd1);
        for (int c = 0; c < 20 && !rd_valid; c++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(rd_valid), 32'd1);
            chk("bp_data_held", 32'(rd_data), 32'hA5);
        end
        @(posedge clk); #1;
        rd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release", 32'(rd_valid), 32'd0);
        wait_drain("bp_drain", 50);

        // Reset during the write pulse (pointer at 3, producer 1 wins)
        req_data[15:8] = 8'h33;
        req            = 4'h2;
        exp_gnt        = '{1};
        got            = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (fifo_write) begin
                got = 1;
                rst = 1'b1;
                req = 4'h0;
            end
        end
        chk("mid_pulse_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk("mid_write_abort", 32'(fifo_write), 32'd0);
        chk("mid_gnt_clear", 32'(gnt), 32'd0);
        chk("mid_last_gnt", 32'(last_gnt), 32'd0);
        chk("mid_fifo_empty", 32'(fifo_empty), 32'd1);
        rst             = 1'b0;
        req_data[15:8]  = 8'hA1;
        req_data[31:24] = 8'h88;
        req             = 4'hA;
        exp_gnt         = '{1, 3};
        exp_rd          = '{8'hA1, 8'h88};
        run_grants(2, 40, 1'b0, 1'b0, 1'b1, got);
        chk("post_rst_grants", 32'(got), 32'd2);
        wait_drain("post_rst_drain", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
